irq_pend_counter: RTL and testbench
===================================

IRQ_PEND_COUNTER -- requirements
Module: irq_pend_counter

Interface
REQ-001 SHALL have parameter N, default 4: width of the pending-event counter; legal range 2..16.
REQ-002 SHALL have port Clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port Evt  input  1: interrupt source level, already synchronous to Clk; a rising edge is one event.
REQ-005 SHALL have port Claim  input  1: handler claims one pending event; single-cycle pulse.
REQ-006 SHALL have port Complete  input  1: handler finished the claimed event; single-cycle pulse.
REQ-007 SHALL have port OvfClr  input  1: clears the sticky overflow flag.
REQ-008 SHALL have port Irq  output  1: interrupt request to the arbiter; registered.
REQ-009 SHALL have port Cnt  output  N: number of pending, unclaimed events; registered.
REQ-010 SHALL have port Ovf  output  1: sticky flag, event lost at saturation; registered.

Function
REQ-011 SHALL detect an event as Evt=1 while the registered previous Evt=0; one event per rising edge; event counted on the same edge it is detected.
REQ-012 SHALL increment Cnt by 1 per event, saturating at 2^N-1.
REQ-013 SHALL decrement Cnt by 1 on an accepted Claim, saturating at 0; decrement computed by a Sub1 instance of width N.
REQ-014 SHALL, when an event and an accepted Claim occur in the same cycle, leave Cnt unchanged (net zero), including when Cnt=2^N-1.
REQ-015 SHALL implement FSM states IDLE (Cnt=0, nothing claimed), PEND (Cnt>0, nothing claimed) and SERV (one event claimed, awaiting Complete).
REQ-016 SHALL transition IDLE->PEND on an event; PEND->SERV on Claim; SERV->PEND on Complete if the next Cnt>0, else SERV->IDLE.
REQ-017 SHALL accept Claim only in PEND; Claim in IDLE or SERV is ignored with no change to Cnt or state.
REQ-018 SHALL ignore Complete outside SERV.
REQ-019 SHALL give Claim priority over Complete when both are asserted in the same cycle.
REQ-020 SHALL keep counting events in every state, including SERV.
REQ-021 SHALL drive Irq=1 exactly while the state is PEND; Irq falls in the cycle after an accepted Claim (latency 1).
REQ-022 SHALL set Ovf on an event arriving while Cnt=2^N-1 and no Claim is accepted in that cycle; OvfClr clears it; a set in the same cycle as OvfClr wins.

Reset
REQ-023 SHALL, on Rst=1, immediately force state=IDLE, Cnt=0, Irq=0, Ovf=0 and previous Evt=0, independent of Clk.
REQ-024 SHALL discard any claimed or pending event on reset mid-operation; an Evt held high through reset release SHALL NOT count until it falls and rises again. The previous-Evt register is loaded with Evt on the first clock after release.

Configuration
REQ-025 SHALL use macro IRQ_PEND_OVF_EN: when defined, Ovf and OvfClr behave per REQ-022; when undefined, Ovf is tied to 0, OvfClr is ignored, and saturation stays silent; ports are present in both cases.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, PEND, SERV) and the saturation constant in the shared package irq_pkg.
REQ-027 SHALL instantiate exactly one sub-module, Sub1 with N passed through, for the decrement path; the increment and edge detect are inline.

Verification
REQ-028 SHALL cover this scenario: N=4, three Evt rising edges -> Cnt=3, Irq=1; Claim -> next cycle Cnt=2, Irq=0, state SERV; Complete -> PEND, Irq=1.
REQ-029 SHALL cover this scenario: 16 events with no Claim -> Cnt=15, Ovf=1; OvfClr -> Ovf=0; with IRQ_PEND_OVF_EN undefined, Ovf stays 0.
REQ-030 SHALL cover this scenario: Cnt=15, an event and a Claim in the same cycle -> Cnt=15, Ovf=0, state SERV.
REQ-031 SHALL cover this scenario: Cnt=1, Claim then Complete -> Cnt=0, state IDLE, Irq=0; a Claim in IDLE -> no change.
REQ-032 SHALL cover this scenario: Cnt=5 in SERV, Rst pulsed between clock edges -> outputs 0 immediately; Evt held at 1 through reset -> Cnt remains 0.
REQ-033 SHALL cover this scenario: Evt held at 1 for 10 cycles -> exactly one event counted.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the pending-interrupt counter.
package irq_pkg;

  localparam int unsigned CNT_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_t;

  // All-ones saturation value for an n-bit counter (n <= CNT_W_MAX)
  function automatic logic [CNT_W_MAX-1:0] sat_max(input int unsigned n);
    return CNT_W_MAX'((33'd1 << n) - 33'd1);
  endfunction

endpackage

// File: rtl/irq_pend_counter_sub1.sv
// Saturating decrement-by-one of an N-bit value (floors at zero).
module Sub1 #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = (a == '0) ? '0 : a - N'(1);

endmodule

// File: rtl/irq_pend_counter.sv
// Pending-interrupt event counter with claim/complete handshake.
// Optional sticky overflow flag enabled by macro IRQ_PEND_OVF_EN.
module irq_pend_counter
  import irq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Evt,
  input  logic         Claim,
  input  logic         Complete,
  input  logic         OvfClr,
  output logic         Irq,
  output logic [N-1:0] Cnt,
  output logic         Ovf
);

  localparam logic [N-1:0] CNT_MAX = N'(sat_max(N));

  state_t       state, state_d;
  logic         evt_q, armed;
  logic         evt_rise, claim_ok, ovf_set, ovf_d;
  logic [N-1:0] cnt_d, cnt_dec;

  Sub1 #(.N(N)) u_sub1 (.a(Cnt), .y(cnt_dec));

  // Next-state, next-count and flag computation
  always_comb begin
    evt_rise = armed & Evt & ~evt_q;
    claim_ok = Claim && (state == PEND);
    cnt_d    = Cnt;
    state_d  = state;

    if (evt_rise && !claim_ok)
      cnt_d = (Cnt == CNT_MAX) ? Cnt : Cnt + N'(1);
    else if (claim_ok && !evt_rise)
      cnt_d = cnt_dec;

    case (state)
      IDLE:    if (evt_rise) state_d = PEND;
      PEND:    if (claim_ok) state_d = SERV;
      SERV:    if (Complete) state_d = (cnt_d != '0) ? PEND : IDLE;
      default: state_d = IDLE;
    endcase

    ovf_set = evt_rise && (Cnt == CNT_MAX) && !claim_ok;
`ifdef IRQ_PEND_OVF_EN
    ovf_d = ovf_set | (Ovf & ~OvfClr);
`else
    ovf_d = 1'b0 & (ovf_set | OvfClr);
`endif
  end

  // armed holds off edge detection for the first clock after reset so a
  // level already high at release is absorbed into evt_q, not counted.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      Cnt   <= '0;
      Irq   <= 1'b0;
      Ovf   <= 1'b0;
      evt_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_d;
      Cnt   <= cnt_d;
      Irq   <= (state_d == PEND);
      Ovf   <= ovf_d;
      evt_q <= Evt;
      armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_pend_counter.sv
// Directed self-checking bench for irq_pend_counter (N=4).
module tb_irq_pend_counter;
  import irq_pkg::*;

`ifdef IRQ_PEND_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       Clk, Rst, Evt, Claim, Complete, OvfClr;
  logic       Irq, Ovf;
  logic [3:0] Cnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  irq_pend_counter #(.N(4)) dut (
    .Clk(Clk), .Rst(Rst), .Evt(Evt), .Claim(Claim), .Complete(Complete),
    .OvfClr(OvfClr), .Irq(Irq), .Cnt(Cnt), .Ovf(Ovf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic evt_pulse();
    Evt = 1'b1; tick();
    Evt = 1'b0; tick();
  endtask

  task automatic do_reset();
    Rst = 1'b1; #2;
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Evt = 0; Claim = 0; Complete = 0; OvfClr = 0;
    Rst = 1'b1; #3;
    n_cmp++; if (Cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", Cnt); end
    n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", Irq); end
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", Ovf); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_claim_complete();
    do_reset();
    repeat (3) evt_pulse();
    n_cmp++; if (Cnt !== 4'd3) begin n_bad++; $display("FAIL three_evt_cnt: got %0d want 3", Cnt); end
    n_cmp++; if (Irq !== 1'b1) begin n_bad++; $display("FAIL three_evt_irq: got %b want 1", Irq); end
    Claim = 1'b1; tick(); Claim = 1'b0;
    n_cmp++; if (Cnt !== 4'd2) begin n_bad++; $display("FAIL claim_cnt: got %0d want 2", Cnt); end
    n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL claim_irq: got %b want 0", Irq); end
    n_cmp++; if (dut.state !== SERV) begin n_bad++; $display("FAIL claim_state: got %0d want %0d", dut.state, SERV); end
    // Claim in SERV is ignored
    Claim = 1'b1; tick(); Claim = 1'b0;
    n_cmp++; if (Cnt !== 4'd2) begin n_bad++; $display("FAIL serv_claim_cnt: got %0d want 2", Cnt); end
    Complete = 1'b1; tick(); Complete = 1'b0;
    n_cmp++; if (dut.state !== PEND) begin n_bad++; $display("FAIL complete_state: got %0d want %0d", dut.state, PEND); end
    n_cmp++; if (Irq !== 1'b1) begin n_bad++; $display("FAIL complete_irq: got %b want 1", Irq); end
    // Claim wins over Complete in the same cycle
    Claim = 1'b1; Complete = 1'b1; tick(); Claim = 1'b0; Complete = 1'b0;
    n_cmp++; if (dut.state !== SERV) begin n_bad++; $display("FAIL prio_state: got %0d want %0d", dut.state, SERV); end
    n_cmp++; if (Cnt !== 4'd1) begin n_bad++; $display("FAIL prio_cnt: got %0d want 1", Cnt); end
    // An event during SERV is still counted
    evt_pulse();
    n_cmp++; if (Cnt !== 4'd2) begin n_bad++; $display("FAIL serv_evt_cnt: got %0d want 2", Cnt); end
    n_cmp++; if (dut.state !== SERV) begin n_bad++; $display("FAIL serv_evt_state: got %0d want %0d", dut.state, SERV); end
  endtask

  task automatic test_drain_to_idle();
    do_reset();
    evt_pulse();
    Claim = 1'b1; tick(); Claim = 1'b0;
    Complete = 1'b1; tick(); Complete = 1'b0;
    n_cmp++; if (Cnt !== 4'd0) begin n_bad++; $display("FAIL drain_cnt: got %0d want 0", Cnt); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL drain_state: got %0d want %0d", dut.state, IDLE); end
    n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL drain_irq: got %b want 0", Irq); end
    Claim = 1'b1; tick(); Claim = 1'b0;
    n_cmp++; if (Cnt !== 4'd0) begin n_bad++; $display("FAIL idle_claim_cnt: got %0d want 0", Cnt); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL idle_claim_state: got %0d want %0d", dut.state, IDLE); end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (16) evt_pulse();
    n_cmp++; if (Cnt !== 4'd15) begin n_bad++; $display("FAIL sat_cnt: got %0d want 15", Cnt); end
    n_cmp++; if (Ovf !== OVF_ON) begin n_bad++; $display("FAIL sat_ovf: got %b want %b", Ovf, OVF_ON); end
    OvfClr = 1'b1; tick(); OvfClr = 1'b0;
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL ovfclr: got %b want 0", Ovf); end
    // Set beats clear in the same cycle
    Evt = 1'b1; OvfClr = 1'b1; tick(); Evt = 1'b0; OvfClr = 1'b0; tick();
    n_cmp++; if (Ovf !== OVF_ON) begin n_bad++; $display("FAIL set_wins: got %b want %b", Ovf, OVF_ON); end
    OvfClr = 1'b1; tick(); OvfClr = 1'b0;
    // Event plus accepted Claim at saturation: net zero, no overflow
    Evt = 1'b1; Claim = 1'b1; tick(); Evt = 1'b0; Claim = 1'b0;
    n_cmp++; if (Cnt !== 4'd15) begin n_bad++; $display("FAIL simul_cnt: got %0d want 15", Cnt); end
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL simul_ovf: got %b want 0", Ovf); end
    n_cmp++; if (dut.state !== SERV) begin n_bad++; $display("FAIL simul_state: got %0d want %0d", dut.state, SERV); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) evt_pulse();
    Claim = 1'b1; tick(); Claim = 1'b0;
    n_cmp++; if (Cnt !== 4'd5) begin n_bad++; $display("FAIL pre_rst_cnt: got %0d want 5", Cnt); end
    #2;
    Evt = 1'b1; Rst = 1'b1;
    #1;
    n_cmp++; if (Cnt !== 4'd0) begin n_bad++; $display("FAIL async_rst_cnt: got %0d want 0", Cnt); end
    n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL async_rst_irq: got %b want 0", Irq); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL async_rst_state: got %0d want %0d", dut.state, IDLE); end
    #1 Rst = 1'b0;
    repeat (4) tick();
    n_cmp++; if (Cnt !== 4'd0) begin n_bad++; $display("FAIL held_evt_cnt: got %0d want 0", Cnt); end
    n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL held_evt_irq: got %b want 0", Irq); end
    Evt = 1'b0; tick();
    Evt = 1'b1; tick();
    n_cmp++; if (Cnt !== 4'd1) begin n_bad++; $display("FAIL rearm_cnt: got %0d want 1", Cnt); end
    Evt = 1'b0; tick();
  endtask

  task automatic test_level_hold();
    do_reset();
    Evt = 1'b1;
    repeat (10) tick();
    Evt = 1'b0; tick();
    n_cmp++; if (Cnt !== 4'd1) begin n_bad++; $display("FAIL level_cnt: got %0d want 1", Cnt); end
    n_cmp++; if (Irq !== 1'b1) begin n_bad++; $display("FAIL level_irq: got %b want 1", Irq); end
  endtask

  initial begin
    Rst = 1'b1; Evt = 0; Claim = 0; Complete = 0; OvfClr = 0;
    test_reset();
    test_claim_complete();
    test_drain_to_idle();
    test_saturation();
    test_reset_mid();
    test_level_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
